// File: rtl/adder_display_scanner.sv
// Registered, time-multiplexed 4-digit seven-segment scanner for the 4-bit adder:
// shows A, B (hex) and {co,sum} in decimal. Optional macro: ADDER_DISPLAY_ZERO_BLANK_EN.
module adder_display_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] sum,
  input  logic       co,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [3:0]    cap_a, cap_b;
  logic [4:0]    cap_tot;
  logic [CW-1:0] cnt;
  logic [1:0]    d;
  logic          tick;
  logic [1:0]    tens;
  logic [3:0]    ones;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;

  // Active-low gfedcba hex glyphs
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_a   <= 4'd0;
      cap_b   <= 4'd0;
      cap_tot <= 5'd0;
    end else if (load) begin
      cap_a   <= a;
      cap_b   <= b;
      cap_tot <= {co, sum};
    end
  end

  // Dwell counter and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      d   <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      d   <= d + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Decimal split of 0..31 by range compare and constant subtract
  always_comb begin
    tens = 2'd0;
    ones = cap_tot[3:0];
    if (cap_tot >= 5'd30) begin
      tens = 2'd3;
      ones = 4'(cap_tot - 5'd30);
    end else if (cap_tot >= 5'd20) begin
      tens = 2'd2;
      ones = 4'(cap_tot - 5'd20);
    end else if (cap_tot >= 5'd10) begin
      tens = 2'd1;
      ones = 4'(cap_tot - 5'd10);
    end
  end

  always_comb begin
    seg_nxt = 7'h7F;
    an_nxt  = 4'b1111;
    case (d)
      2'd0: begin
        an_nxt  = 4'b1110;
        seg_nxt = hex7(ones);
      end
      2'd1: begin
        an_nxt  = 4'b1101;
        seg_nxt = hex7({2'b00, tens});
`ifdef ADDER_DISPLAY_ZERO_BLANK_EN
        if (cap_tot < 5'd10) seg_nxt = 7'h7F;
`endif
      end
      2'd2: begin
        an_nxt  = 4'b1011;
        seg_nxt = hex7(cap_b);
      end
      default: begin
        an_nxt  = 4'b0111;
        seg_nxt = hex7(cap_a);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 7'h7F;
      an  <= 4'b1111;
      dp  <= 1'b1;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_display_scanner.sv
// Scoreboard bench for adder_display_scanner with REFRESH_DIV=4: a cycle model pushes
// the expected {dp,an,seg} for every edge and each test pops and compares after the edge.
module tb_adder_display_scanner;

  localparam int R = 4;

  logic       clk, rst, load, co;
  logic [3:0] a, b, sum;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int         m_cnt;
  logic [1:0] m_d;
  logic [3:0] m_a, m_b;
  logic [4:0] m_tot;
  logic [11:0] sb [$];

  adder_display_scanner #(.REFRESH_DIV(R)) dut (
    .clk(clk), .rst(rst), .load(load), .a(a), .b(b), .sum(sum), .co(co),
    .seg(seg), .an(an), .dp(dp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] expect_out(input logic r, input logic [1:0] dd,
                                             input logic [3:0] xa, input logic [3:0] xb,
                                             input logic [4:0] tot);
    logic [6:0] s;
    logic [3:0] n;
    int t;
    t = int'(tot);
    if (r) return {1'b1, 4'hF, 7'h7F};
    n = ~(4'b0001 << dd);
    case (dd)
      2'd0: s = HEX[t % 10];
      2'd1: begin
        s = HEX[t / 10];
`ifdef ADDER_DISPLAY_ZERO_BLANK_EN
        if (t < 10) s = 7'h7F;
`endif
      end
      2'd2: s = HEX[xb];
      default: s = HEX[xa];
    endcase
    return {1'b1, n, s};
  endfunction

  // One clock edge: push expected outputs from the pre-edge model, then advance the model
  task automatic step();
    logic [11:0] e;
    e = expect_out(rst, m_d, m_a, m_b, m_tot);
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_d = 2'd0; m_a = 4'd0; m_b = 4'd0; m_tot = 5'd0;
    end else begin
      if (load) begin m_a = a; m_b = b; m_tot = {co, sum}; end
      if (m_cnt == R - 1) begin m_cnt = 0; m_d = m_d + 2'd1; end
      else m_cnt = m_cnt + 1;
    end
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    logic [3:0] seq [4];
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
    #2 rst = 1'b1;
    m_cnt = 0; m_d = 2'd0; m_a = 4'd0; m_b = 4'd0; m_tot = 5'd0;
    #1;
    n_total++;
    if ({dp, an, seg} !== {1'b1, 4'hF, 7'h7F})
      $display("FAIL reset_async: got dp/an/seg %b/%b/%b want 1/1111/1111111", dp, an, seg);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step();
      e = sb.pop_front();
      n_total++;
      if ({dp, an, seg} !== e) $display("FAIL reset_hold: got %h want %h", {dp, an, seg}, e);
      else n_pass++;
    end
    rst = 1'b0;
    for (int i = 0; i < 5 * R; i++) begin
      step();
      e = sb.pop_front();
      n_total++;
      if ({dp, an, seg} !== e) $display("FAIL reset_scan cyc %0d: got %h want %h", i, {dp, an, seg}, e);
      else n_pass++;
      n_total++;
      if (an !== seq[(i / R) % 4]) $display("FAIL an_sequence cyc %0d: got %b want %b", i, an, seq[(i / R) % 4]);
      else n_pass++;
    end
  endtask

  // Load a capture for one cycle and check a full frame, including fixed glyphs per digit
  task automatic test_load(input string name, input logic [3:0] xa, input logic [3:0] xb,
                           input logic [4:0] tot, input logic [6:0] g0, input logic [6:0] g1,
                           input logic [6:0] g2, input logic [6:0] g3);
    logic [11:0] e;
    logic [6:0] want;
    a = xa; b = xb; sum = tot[3:0]; co = tot[4]; load = 1'b1;
    step();
    e = sb.pop_front();
    n_total++;
    if ({dp, an, seg} !== e) $display("FAIL %s load_edge: got %h want %h", name, {dp, an, seg}, e);
    else n_pass++;
    load = 1'b0;
    for (int i = 0; i < 4 * R; i++) begin
      step();
      e = sb.pop_front();
      n_total++;
      if ({dp, an, seg} !== e) $display("FAIL %s frame cyc %0d: got %h want %h", name, i, {dp, an, seg}, e);
      else n_pass++;
      case (an)
        4'b1110: want = g0;
        4'b1101: want = g1;
        4'b1011: want = g2;
        default: want = g3;
      endcase
      n_total++;
      if (seg !== want) $display("FAIL %s glyph an=%b: got %b want %b", name, an, seg, want);
      else n_pass++;
    end
  endtask

  task automatic test_load_tick();
    logic [11:0] e;
    int guard;
    guard = 0;
    while (!(m_d == 2'd3 && m_cnt == R - 1) && guard < 8 * R) begin
      step();
      e = sb.pop_front();
      n_total++;
      if ({dp, an, seg} !== e) $display("FAIL tick_wait: got %h want %h", {dp, an, seg}, e);
      else n_pass++;
      guard++;
    end
    n_total++;
    if (guard >= 8 * R) $display("FAIL tick_wait timeout: got %0d cycles want <%0d", guard, 8 * R);
    else n_pass++;
    sum = 4'd9; co = 1'b0; load = 1'b1;
    step();
    e = sb.pop_front();
    n_total++;
    if ({dp, an, seg} !== e) $display("FAIL tick_load_edge: got %h want %h", {dp, an, seg}, e);
    else n_pass++;
    load = 1'b0;
    step();
    e = sb.pop_front();
    n_total++;
    if ({an, seg} !== {4'b1110, 7'b0010000})
      $display("FAIL tick_new_digit: got an/seg %b/%b want 1110/0010000", an, seg);
    else n_pass++;
    n_total++;
    if ({dp, an, seg} !== e) $display("FAIL tick_new_digit_sb: got %h want %h", {dp, an, seg}, e);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [11:0] e;
    int guard;
    guard = 0;
    while (!(m_d == 2'd2 && m_cnt == 1) && guard < 8 * R) begin
      step();
      e = sb.pop_front();
      n_total++;
      if ({dp, an, seg} !== e) $display("FAIL arst_wait: got %h want %h", {dp, an, seg}, e);
      else n_pass++;
      guard++;
    end
    n_total++;
    if (guard >= 8 * R) $display("FAIL arst_wait timeout: got %0d cycles want <%0d", guard, 8 * R);
    else n_pass++;
    #2 rst = 1'b1;
    m_cnt = 0; m_d = 2'd0; m_a = 4'd0; m_b = 4'd0; m_tot = 5'd0;
    #1;
    n_total++;
    if ({dp, an, seg} !== {1'b1, 4'hF, 7'h7F})
      $display("FAIL arst_immediate: got dp/an/seg %b/%b/%b want 1/1111/1111111", dp, an, seg);
    else n_pass++;
    step();
    e = sb.pop_front();
    n_total++;
    if ({dp, an, seg} !== e) $display("FAIL arst_hold: got %h want %h", {dp, an, seg}, e);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 2 * R; i++) begin
      step();
      e = sb.pop_front();
      n_total++;
      if ({dp, an, seg} !== e) $display("FAIL arst_restart cyc %0d: got %h want %h", i, {dp, an, seg}, e);
      else n_pass++;
      if (i < R) begin
        n_total++;
        if ({an, seg} !== {4'b1110, 7'b1000000})
          $display("FAIL arst_digit0 cyc %0d: got an/seg %b/%b want 1110/1000000", i, an, seg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sweep();
    logic [11:0] e;
    logic [4:0] tot;
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          tot = 5'(ai + bi + ci);
          a = 4'(ai); b = 4'(bi); sum = tot[3:0]; co = tot[4]; load = 1'b1;
          step();
          e = sb.pop_front();
          n_total++;
          if ({dp, an, seg} !== e) $display("FAIL sweep_load %0d+%0d+%0d: got %h want %h", ai, bi, ci, {dp, an, seg}, e);
          else n_pass++;
          load = 1'b0;
          for (int i = 0; i < 4 * R; i++) begin
            step();
            e = sb.pop_front();
            n_total++;
            if ({dp, an, seg} !== e)
              $display("FAIL sweep %0d+%0d+%0d cyc %0d: got %h want %h", ai, bi, ci, i, {dp, an, seg}, e);
            else n_pass++;
          end
        end
  endtask

  task automatic test_hold_load();
    logic [11:0] e;
    load = 1'b1;
    for (int i = 0; i < 4 * R; i++) begin
      a = 4'($urandom_range(15)); b = 4'($urandom_range(15));
      sum = 4'($urandom_range(15)); co = 1'($urandom_range(1));
      step();
      e = sb.pop_front();
      n_total++;
      if ({dp, an, seg} !== e) $display("FAIL hold_load cyc %0d: got %h want %h", i, {dp, an, seg}, e);
      else n_pass++;
    end
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; a = 4'd0; b = 4'd0; sum = 4'd0; co = 1'b0;
    test_reset();
    test_load("t17", 4'hA, 4'h7, 5'd17, 7'b1111000, 7'b1111001, 7'b1111000, 7'b0001000);
    test_load("t31", 4'hF, 4'hF, 5'd31, 7'b1111001, 7'b0110000, 7'b0001110, 7'b0001110);
`ifdef ADDER_DISPLAY_ZERO_BLANK_EN
    test_load("t0", 4'h0, 4'h0, 5'd0, 7'b1000000, 7'b1111111, 7'b1000000, 7'b1000000);
`else
    test_load("t0", 4'h0, 4'h0, 5'd0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
`endif
    test_load_tick();
    test_hold_load();
    test_async_reset();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
